// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter_priority_sel.sv
// Winner select for the shared memory port: data first, with a burst counter that
// forces a fetch grant after MAX_D_BURST consecutive data grants while fetch waits.
module arb_priority_sel
   import mem_arb_pkg::*;
#(
   parameter int MAX_D_BURST = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en,
   input  logic i_req,
   input  logic d_req,
   output logic grant_i,
   output logic grant_d
);

   logic [3:0] burst_q;
   logic [3:0] burst_d;

   // Grant decision and next burst count.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (arb_en) begin
         if (d_req && (!i_req || (burst_q != 4'(MAX_D_BURST)))) begin
            grant_d = 1'b1;
         end else if (i_req) begin
            grant_i = 1'b1;
         end else begin
            grant_d = 1'b0;
         end
      end else begin
         grant_i = 1'b0;
      end

      if (grant_i || !i_req) begin
         burst_d = 4'd0;
      end else if (grant_d) begin
         burst_d = burst_q + 4'd1;
      end else begin
         burst_d = burst_q;
      end
   end

   // Burst counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_q <= 4'd0;
      end else begin
         burst_q <= burst_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one mem_valid/mem_rdy port between fetch and load/store, one transaction at a time.
// Optional downstream timeout with sticky err: define MEM_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_D_BURST    = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic [31:0] i_addr,
   input  logic        i_cancel,
   output logic        i_ready,
   output logic [31:0] i_rdata,
   input  logic        d_valid,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_rdy,
   input  logic [31:0] mem_rdata,
   output logic        err
);

   if (MAX_D_BURST < 1 || MAX_D_BURST > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
      $error("mem_port_arbiter: parameter out of range");
   end

   arb_state_t  state_q,     state_d;
   owner_t      owner_q,     owner_d;
   logic        mem_valid_q, mem_valid_d;
   logic        mem_instr_q, mem_instr_d;
   logic [31:0] addr_q,      addr_d;
   logic [31:0] wdata_q,     wdata_d;
   logic [3:0]  wstrb_q,     wstrb_d;
   logic        cancel_q,    cancel_d;
   logic        i_ready_q,   i_ready_d;
   logic [31:0] i_rdata_q,   i_rdata_d;
   logic        d_ready_q,   d_ready_d;
   logic [31:0] d_rdata_q,   d_rdata_d;

   logic        i_req_s;
   logic        grant_i_s;
   logic        grant_d_s;
   logic        timeout_s;
   logic        cancel_hit_s;
   logic [31:0] rdata_s;

   // A fetch raised together with a flush is not a request.
   assign i_req_s = i_valid & ~i_cancel;

   arb_priority_sel #(
      .MAX_D_BURST (MAX_D_BURST)
   ) u_sel (
      .clk     (clk),
      .rst     (rst),
      .arb_en  (state_q == IDLE),
      .i_req   (i_req_s),
      .d_req   (d_valid),
      .grant_i (grant_i_s),
      .grant_d (grant_d_s)
   );

   // FSM next state, request latch and response generation.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      mem_valid_d  = mem_valid_q;
      mem_instr_d  = mem_instr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      cancel_d     = cancel_q;
      i_ready_d    = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_ready_d    = 1'b0;
      d_rdata_d    = d_rdata_q;
      cancel_hit_s = cancel_q;
      rdata_s      = mem_rdy ? mem_rdata : TIMEOUT_RDATA;

      case (state_q)
         IDLE: begin
            cancel_d = 1'b0;
            if (grant_i_s) begin
               state_d     = BUSY;
               owner_d     = OWN_I;
               mem_valid_d = 1'b1;
               mem_instr_d = 1'b1;
               addr_d      = i_addr;
               wdata_d     = 32'd0;
               wstrb_d     = 4'd0;
            end else if (grant_d_s) begin
               state_d     = BUSY;
               owner_d     = OWN_D;
               mem_valid_d = 1'b1;
               mem_instr_d = 1'b0;
               addr_d      = d_addr;
               wdata_d     = d_wdata;
               wstrb_d     = d_wstrb;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            cancel_hit_s = cancel_q | ((owner_q == OWN_I) & i_cancel);
            cancel_d     = cancel_hit_s;
            if (mem_rdy || timeout_s) begin
               state_d     = RESP;
               mem_valid_d = 1'b0;
               if (owner_q == OWN_I) begin
                  if (!cancel_hit_s) begin
                     i_ready_d = 1'b1;
                     i_rdata_d = rdata_s;
                  end else begin
                     i_ready_d = 1'b0;
                  end
               end else begin
                  d_ready_d = 1'b1;
                  d_rdata_d = (mem_rdy && (wstrb_q != 4'd0)) ? 32'd0 : rdata_s;
               end
            end else begin
               state_d = BUSY;
            end
         end
         RESP: begin
            state_d  = IDLE;
            cancel_d = 1'b0;
         end
         default: begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            cancel_d    = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any downstream request immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_D;
         mem_valid_q <= 1'b0;
         mem_instr_q <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         wstrb_q     <= 4'd0;
         cancel_q    <= 1'b0;
         i_ready_q   <= 1'b0;
         i_rdata_q   <= 32'd0;
         d_ready_q   <= 1'b0;
         d_rdata_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_valid_q <= mem_valid_d;
         mem_instr_q <= mem_instr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         cancel_q    <= cancel_d;
         i_ready_q   <= i_ready_d;
         i_rdata_q   <= i_rdata_d;
         d_ready_q   <= d_ready_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   logic [7:0] wait_q, wait_d;
   logic       err_q,  err_d;

   assign timeout_s = (state_q == BUSY) && (wait_q == 8'(TIMEOUT_CYCLES - 1));

   // Wait counter runs only while BUSY; err latches a timeout until reset.
   always_comb begin
      wait_d = wait_q;
      err_d  = err_q;
      if (state_q == BUSY) begin
         wait_d = wait_q + 8'd1;
         if (timeout_s && !mem_rdy) begin
            err_d = 1'b1;
         end else begin
            err_d = err_q;
         end
      end else begin
         wait_d = 8'd0;
      end
   end

   // Timeout counter and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q <= 8'd0;
         err_q  <= 1'b0;
      end else begin
         wait_q <= wait_d;
         err_q  <= err_d;
      end
   end

   assign err = err_q;
`else
   assign timeout_s = 1'b0;
   assign err       = 1'b0;
`endif

   // A flush arriving in the strobe cycle itself still hides that strobe.
   assign i_ready   = i_ready_q & ~i_cancel;
   assign i_rdata   = i_rdata_q;
   assign d_ready   = d_ready_q;
   assign d_rdata   = d_rdata_q;
   assign mem_valid = mem_valid_q;
   assign mem_instr = mem_instr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int MAXB = 4;
   localparam int TO   = 8;
`ifdef MEM_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid = 1'b0, i_cancel = 1'b0, d_valid = 1'b0, mem_rdy;
   logic [31:0] i_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0, mem_rdata;
   logic [3:0]  d_wstrb = 4'd0;
   logic        i_ready, d_ready, mem_valid, mem_instr, err;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;

   int          n_checks = 0;
   int          n_pass   = 0;

   int          rdy_delay  = 0;
   logic [31:0] rdata_cfg  = 32'd0;
   logic [31:0] rdata_step = 32'd0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_D_BURST(MAXB), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_addr(i_addr), .i_cancel(i_cancel), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
      .err(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // ---------------- reference model (one transaction at a time) ----------------
   bit          m_busy, m_resp, m_own_i, m_cancel;
   bit [31:0]   m_addr, m_wdata;
   bit [3:0]    m_wstrb;
   int          m_burst, m_wait;
   bit          e_i_ready, e_d_ready, e_err;
   bit [31:0]   e_i_rdata, e_d_rdata;
   bit          m_log[$];
   bit          d_log[$];

   always @(posedge clk or posedge rst) begin
      bit        ireq;
      bit [31:0] rd;
      if (rst) begin
         m_busy = 0; m_resp = 0; m_own_i = 0; m_cancel = 0;
         m_addr = 0; m_wdata = 0; m_wstrb = 0; m_burst = 0; m_wait = 0;
         e_i_ready = 0; e_d_ready = 0; e_err = 0; e_i_rdata = 0; e_d_rdata = 0;
      end else begin
         ireq = i_valid && !i_cancel;
         e_i_ready = 0;
         e_d_ready = 0;
         if (m_resp) begin
            m_resp = 0; m_cancel = 0;
            if (!ireq) m_burst = 0;
         end else if (m_busy) begin
            if (!ireq) m_burst = 0;
            if (m_own_i && i_cancel) m_cancel = 1;
            m_wait++;
            if (mem_rdy || (TIMEOUT_ON && m_wait == TO)) begin
               rd = mem_rdy ? mem_rdata : 32'hDEAD_BEEF;
               if (!mem_rdy) e_err = 1;
               m_busy = 0; m_resp = 1;
               if (m_own_i) begin
                  if (!m_cancel) begin e_i_ready = 1; e_i_rdata = rd; end
               end else begin
                  e_d_ready = 1;
                  e_d_rdata = (mem_rdy && m_wstrb != 0) ? 32'd0 : rd;
               end
            end
         end else begin
            m_wait = 0;
            if (d_valid && (!ireq || m_burst < MAXB)) begin
               m_busy = 1; m_own_i = 0; m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_wstrb;
               m_log.push_back(1'b0);
               m_burst = ireq ? m_burst + 1 : 0;
            end else if (ireq) begin
               m_busy = 1; m_own_i = 1; m_addr = i_addr; m_wdata = 0; m_wstrb = 0;
               m_log.push_back(1'b1);
               m_burst = 0;
            end else begin
               m_burst = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit prev_mv = 0;
   int i_ready_cnt = 0;
   int d_ready_cnt = 0;
   always @(negedge clk) begin
      check("mem_valid", {31'd0, mem_valid}, {31'd0, m_busy});
      if (m_busy) begin
         check("mem_instr", {31'd0, mem_instr}, {31'd0, m_own_i});
         check("mem_addr", mem_addr, m_addr);
         check("mem_wdata", mem_wdata, m_wdata);
         check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m_wstrb});
      end
      check("i_ready", {31'd0, i_ready}, {31'd0, e_i_ready && !i_cancel});
      check("d_ready", {31'd0, d_ready}, {31'd0, e_d_ready});
      check("i_rdata", i_rdata, e_i_rdata);
      check("d_rdata", d_rdata, e_d_rdata);
      check("err", {31'd0, err}, {31'd0, e_err});
      if (mem_valid && !prev_mv) d_log.push_back(mem_instr);
      prev_mv = mem_valid;
      if (i_ready) i_ready_cnt++;
      if (d_ready) d_ready_cnt++;
   end

   // ---------------- downstream responder ----------------
   initial begin
      int cnt;
      int idx;
      cnt = 0; idx = 0;
      mem_rdy = 1'b0; mem_rdata = 32'd0;
      forever begin
         @(posedge clk); #1;
         if (mem_rdy) begin
            mem_rdy = 1'b0; cnt = 0;
         end else if (mem_valid) begin
            if (rdy_delay >= 0 && cnt >= rdy_delay) begin
               mem_rdy = 1'b1;
               mem_rdata = rdata_cfg + rdata_step * 32'(idx);
               idx++;
            end
            cnt++;
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_ready(input bit is_i, input int budget, output int cycles);
      cycles = 0;
      while (!(is_i ? i_ready : d_ready) && cycles < budget) begin
         tick();
         cycles++;
      end
      if (cycles >= budget) check(is_i ? "i_ready timeout" : "d_ready timeout", 32'(cycles), 32'(budget - 1));
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int cyc, base_m, base_d, cnt0, n;
      repeat (3) tick();
      check("reset mem_valid", {31'd0, mem_valid}, 32'd0);
      check("reset i_ready", {31'd0, i_ready}, 32'd0);
      check("reset d_ready", {31'd0, d_ready}, 32'd0);
      check("reset i_rdata", i_rdata, 32'd0);
      check("reset err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      tick();

      // fetch only, mem_rdy one cycle after mem_valid
      rdy_delay = 1; rdata_cfg = 32'h0010_0093; rdata_step = 32'd0;
      i_valid = 1'b1; i_addr = 32'h0000_0100;
      tick();
      check("fetch mem_valid", {31'd0, mem_valid}, 32'd1);
      check("fetch mem_instr", {31'd0, mem_instr}, 32'd1);
      check("fetch mem_addr", mem_addr, 32'h0000_0100);
      wait_ready(1'b1, 20, cyc);
      check("fetch latency", 32'(cyc + 2), 32'd4);
      check("fetch i_rdata", i_rdata, 32'h0010_0093);
      i_valid = 1'b0;
      tick();

      // store only
      rdy_delay = 0; rdata_cfg = 32'h1234_5678;
      d_valid = 1'b1; d_addr = 32'h0200_0004; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'hF;
      tick();
      check("store mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
      check("store mem_instr", {31'd0, mem_instr}, 32'd0);
      check("store mem_wdata", mem_wdata, 32'hCAFE_F00D);
      wait_ready(1'b0, 20, cyc);
      check("store d_rdata", d_rdata, 32'd0);
      d_valid = 1'b0;
      tick();

      // load only
      rdy_delay = 2; rdata_cfg = 32'h89AB_CDEF;
      d_valid = 1'b1; d_addr = 32'h0200_0008; d_wdata = 32'd0; d_wstrb = 4'h0;
      wait_ready(1'b0, 20, cyc);
      check("load d_rdata", d_rdata, 32'h89AB_CDEF);
      d_valid = 1'b0;
      repeat (3) tick();
      check("load d_rdata hold", d_rdata, 32'h89AB_CDEF);

      // contention, both requesters held
      rdy_delay = 0; rdata_cfg = 32'h0000_1000; rdata_step = 32'd1;
      base_m = m_log.size(); base_d = d_log.size();
      i_valid = 1'b1; i_addr = 32'h0000_0400;
      d_valid = 1'b1; d_addr = 32'h0000_0800; d_wstrb = 4'h0;
      n = 0;
      while (d_log.size() - base_d < 10 && n < 300) begin tick(); n++; end
      check("contention grants seen", 32'(d_log.size() - base_d), 32'd10);
      wait_ready(1'b1, 20, cyc);
      i_valid = 1'b0; d_valid = 1'b0;
      tick();
      for (int k = 0; k < 10; k++) begin
         bit exp_i;
         exp_i = (k % 5 == 4);
         if (base_m + k < m_log.size())
            check($sformatf("model order %0d", k), {31'd0, m_log[base_m + k]}, {31'd0, exp_i});
         if (base_d + k < d_log.size())
            check($sformatf("dut order %0d", k), {31'd0, d_log[base_d + k]}, {31'd0, exp_i});
      end

      // flush during BUSY, completion 3 cycles later
      rdy_delay = 3; rdata_cfg = 32'h0BAD_0BAD; rdata_step = 32'd0;
      cnt0 = i_ready_cnt;
      i_valid = 1'b1; i_addr = 32'h0000_0200;
      tick();
      check("flush mem_valid", {31'd0, mem_valid}, 32'd1);
      i_cancel = 1'b1; i_valid = 1'b0;
      tick();
      i_cancel = 1'b0;
      repeat (6) tick();
      check("flush i_ready pulses", 32'(i_ready_cnt - cnt0), 32'd0);
      check("flush mem_valid done", {31'd0, mem_valid}, 32'd0);
      rdy_delay = 0;
      d_valid = 1'b1; d_addr = 32'h0000_0300; d_wstrb = 4'h0;
      wait_ready(1'b0, 20, cyc);
      check("post-flush d_rdata", d_rdata, 32'h0BAD_0BAD);
      d_valid = 1'b0;
      tick();

      // flush in the strobe cycle itself
      rdy_delay = 0; rdata_cfg = 32'h0000_0777;
      i_valid = 1'b1; i_addr = 32'h0000_0204;
      tick(); tick();
      i_cancel = 1'b1; i_valid = 1'b0;
      #1;
      check("resp-cycle cancel i_ready", {31'd0, i_ready}, 32'd0);
      tick();
      i_cancel = 1'b0;
      tick();

      // reset while mem_valid is high
      rdy_delay = -1;
      cnt0 = d_ready_cnt;
      d_valid = 1'b1; d_addr = 32'h0000_0500; d_wstrb = 4'h0;
      tick();
      check("pre-reset mem_valid", {31'd0, mem_valid}, 32'd1);
      #2 rst = 1'b1;
      #1 check("async reset mem_valid", {31'd0, mem_valid}, 32'd0);
      d_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("reset no d_ready", 32'(d_ready_cnt - cnt0), 32'd0);
      rdy_delay = 0; rdata_cfg = 32'h0000_ABCD;
      i_valid = 1'b1; i_addr = 32'h0000_0600;
      wait_ready(1'b1, 20, cyc);
      check("post-reset i_rdata", i_rdata, 32'h0000_ABCD);
      i_valid = 1'b0;
      tick();

`ifdef MEM_TIMEOUT_EN
      rdy_delay = -1;
      d_valid = 1'b1; d_addr = 32'h0000_0700; d_wstrb = 4'h0;
      tick();
      n = 0;
      while (mem_valid && n < 50) begin n++; tick(); end
      check("timeout busy cycles", 32'(n), 32'd8);
      check("timeout d_ready", {31'd0, d_ready}, 32'd1);
      check("timeout d_rdata", d_rdata, 32'hDEAD_BEEF);
      check("timeout err", {31'd0, err}, 32'd1);
      d_valid = 1'b0;
      repeat (3) tick();
      check("timeout err sticky", {31'd0, err}, 32'd1);
      rst = 1'b1;
      tick();
      check("err cleared by rst", {31'd0, err}, 32'd0);
      rst = 1'b0;
      tick();
`else
      check("err tied low", {31'd0, err}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one PicoSoC-style memory port (mem_valid/mem_rdy, native 32-bit) between the core's instruction-fetch requester and data load/store requester.
- Sits between the core's fetch and load/store units and the SPI flash / SRAM master.
- Registers each granted request, runs exactly one downstream transaction at a time and returns a one-cycle registered response to the winner.
- Data requests have priority; a burst limit prevents instruction starvation.

Parameters:
- MAX_D_BURST, 4, consecutive data grants allowed while an instruction request waits; must be 1..15.
- TIMEOUT_CYCLES, 255, downstream wait limit in cycles; used only when the optional feature is compiled in; must be 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  fetch request; held with i_addr stable until i_ready
- i_addr  in  32  fetch address
- i_cancel  in  1  flush: drop the outstanding/pending fetch response
- i_ready  out  1  one-cycle response strobe for fetch
- i_rdata  out  32  fetch data, valid with i_ready
- d_valid  in  1  data request; held with d_addr/d_wdata/d_wstrb stable until d_ready
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  byte strobes; 0 = load, nonzero = store
- d_ready  out  1  one-cycle response strobe for data
- d_rdata  out  32  load data, valid with d_ready; 0 for stores
- mem_valid  out  1  downstream request
- mem_instr  out  1  1 when the granted owner is fetch
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream store data
- mem_wstrb  out  4  downstream strobes
- mem_rdy  in  1  downstream completion; mem_rdata valid in the same cycle
- mem_rdata  in  32  downstream read data
- err  out  1  sticky timeout flag (optional feature only, else tied 0)

Behaviour:
- Reset (async, rst=1) clears everything: state=IDLE, burst counter=0 and all outputs 0.
- All outputs are registered.
- FSM states:
  - IDLE -> BUSY when any valid is sampled.
  - BUSY -> RESP on mem_rdy.
  - RESP -> IDLE unconditionally.
- Arbitration, in IDLE only:
  - Only d_valid: grant data.
  - Only i_valid (and no i_cancel in that cycle): grant fetch.
  - Both: grant data unless burst counter == MAX_D_BURST, then grant fetch.
  - The burst counter increments on a data grant made while i_valid is high, and clears on any fetch grant or when i_valid is low.
- Grant cycle N (in IDLE):
  - Latch owner, address, wdata and wstrb.
  - mem_valid=1 from cycle N+1 and held through the mem_rdy cycle.
  - Fetch grant: mem_instr=1, mem_wstrb=0, mem_wdata=0.
- mem_rdy sampled high in cycle M (BUSY):
  - mem_valid drops at M+1.
  - mem_rdata is captured.
  - The owner's ready strobe and rdata are driven at M+1 (state RESP) for exactly one cycle.
- Minimum latency from request to ready is 3 cycles (mem_rdy in the first BUSY cycle).
- No new grant is made in RESP, so the requester can drop valid. At most one transaction is outstanding.
- mem_rdy is ignored outside BUSY.
- i_cancel:
  - In BUSY with fetch owner: sets a cancel flag. The downstream transaction still completes (it cannot be aborted), but i_ready is suppressed in RESP.
  - In RESP with fetch owner: suppresses that cycle's i_ready.
  - Never affects data transactions.
  - Flag clears on entry to IDLE.
- i_rdata/d_rdata hold their last value between strobes. d_rdata=0 on store responses.
- Simultaneous i_cancel and i_valid in IDLE: no fetch grant that cycle.
- Reset mid-transaction: the downstream request is dropped immediately (mem_valid=0) and no response is issued.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter runs in BUSY.
  - When the count reaches TIMEOUT_CYCLES without mem_rdy: deassert mem_valid, go to RESP, return rdata=32'hDEAD_BEEF with the owner's ready strobe (fetch cancel still applies), and set err=1 (sticky until rst).
- MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; err tied 0.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY, RESP};
  - owner_t enum {OWN_I, OWN_D};
  - TIMEOUT_RDATA constant 32'hDEAD_BEEF.
- Sub-module arb_priority_sel (combinational winner select plus burst-counter register) is natural; the FSM and datapath stay in the top module.

Test Plan:
- Fetch only: i_valid, i_addr=0x0000_0100, mem_rdy one cycle after mem_valid with mem_rdata=0x0010_0093 -> mem_instr=1, i_ready one cycle later with i_rdata=0x0010_0093; total latency 4.
- Store only: d_addr=0x0200_0004, d_wdata=0xCAFE_F00D, d_wstrb=4'hF -> mem_wstrb=4'hF, mem_instr=0, d_ready with d_rdata=0.
- Contention with MAX_D_BURST=4: i_valid and d_valid held continuously -> grant order D,D,D,D,I,D,D,D,D,I.
- Flush: fetch granted, i_cancel pulsed in BUSY, mem_rdy 3 cycles later -> transaction completes, no i_ready, next request granted from IDLE.
- Reset: rst asserted while mem_valid=1 -> mem_valid=0 asynchronously, no ready strobe, state IDLE after release.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mem_rdy never asserted -> mem_valid drops after 8 BUSY cycles, d_ready with 0xDEAD_BEEF, err=1 until rst.
